regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 27 ++
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared widths, types and write-back requester indices
package regfile_wb_arbiter_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

    // Write-back requester indices
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MDU = 2;

    typedef logic [DATA_WIDTH-1:0]     data_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - combinational round-robin arbiter with one-hot grant
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;

    // Search from ptr upward, wrapping modulo N; the first active request wins
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-back arbiter; REGFILE_SCOREBOARD_EN adds busy scoreboard
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ-1:0][REG_ADDR_WIDTH-1:0]  req_rd,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic                                    wb_stall,
    output logic                                    wr_en,
    output logic [REG_ADDR_WIDTH-1:0]               wr_addr,
    output logic [DATA_WIDTH-1:0]                   wr_data,
    input  logic                                    issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]               issue_rd,
    input  logic [REG_ADDR_WIDTH-1:0]               rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]               rs2_addr,
    output logic                                    rs1_busy,
    output logic                                    rs2_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] arb_req, gnt;
    logic               xfer;
    logic [PTR_W-1:0]   sel_idx;
    reg_addr_t          sel_rd;
    data_t              sel_data;
    logic               wr_en_q, wr_en_d;
    reg_addr_t          wr_addr_q, wr_addr_d;
    data_t              wr_data_q, wr_data_d;

    assign arb_req = wb_stall ? '0 : req_valid;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr_arbiter (
        .req (arb_req),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    // Grants are suppressed while reset is held so no requester sees an accept
    assign req_ready = rst_n ? gnt : '0;

    // Pick out the granted requester's index, destination and data
    always_comb begin
        xfer     = 1'b0;
        sel_idx  = '0;
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                xfer     = 1'b1;
                sel_idx  = PTR_W'(i);
                sel_rd   = req_rd[i];
                sel_data = req_data[i];
            end
        end
    end

    // Rotate the pointer past the winner; writes to x0 are accepted but not performed
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            rr_ptr_d = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
            if (sel_rd != '0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_rd;
                wr_data_d = sel_data;
            end
        end
    end

    // Arbiter pointer and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Issue marks a destination pending, write-back clears it; issue wins, x0 never busy
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A register being written back this cycle already reads as ready
    assign rs1_busy = busy_q[rs1_addr] & ~(wr_en_q && (wr_addr_q == rs1_addr));
    assign rs2_busy = busy_q[rs2_addr] & ~(wr_en_q && (wr_addr_q == rs2_addr));
`else
    logic sb_unused;
    assign sb_unused = ^{issue_valid, issue_rd, rs1_addr, rs2_addr};
    assign rs1_busy  = 1'b0;
    assign rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int N = 3;
`ifdef REGFILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                   rst_n;
    logic [N-1:0]                           req_valid;
    logic [N-1:0][REG_ADDR_WIDTH-1:0]       req_rd;
    logic [N-1:0][DATA_WIDTH-1:0]           req_data;
    logic [N-1:0]                           req_ready;
    logic                                   wb_stall;
    logic                                   wr_en;
    logic [REG_ADDR_WIDTH-1:0]              wr_addr;
    logic [DATA_WIDTH-1:0]                  wr_data;
    logic                                   issue_valid;
    logic [REG_ADDR_WIDTH-1:0]              issue_rd;
    logic [REG_ADDR_WIDTH-1:0]              rs1_addr, rs2_addr;
    logic                                   rs1_busy, rs2_busy;

    regfile_wb_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wb_stall    (wb_stall),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pending request per requester, pointer, write port, busy set
    bit          m_v[N];
    logic [4:0]  m_rd[N];
    logic [31:0] m_data[N];
    int          m_ptr;
    bit          m_wr_en;
    logic [4:0]  m_wr_addr;
    logic [31:0] m_wr_data;
    bit          m_busy[32];

    logic [N-1:0] obs_ready;
    logic         obs_wr_en;
    logic [4:0]   obs_wr_addr;
    logic [31:0]  obs_wr_data;
    logic         obs_rs1;

    task automatic model_reset();
        m_ptr     = 0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        foreach (m_v[i]) m_v[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
        m_v[i]    = 1'b1;
        m_rd[i]   = rd;
        m_data[i] = data;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = m_v[i];
            req_rd[i]    = m_rd[i];
            req_data[i]  = m_data[i];
        end
    endtask

    function automatic int exp_grant();
        if (wb_stall) return -1;
        for (int k = 0; k < N; k++)
            if (m_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!SB) return 1'b0;
        if (m_wr_en && (m_wr_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    // One clock: check combinational outputs mid-cycle, advance model, check registered outputs
    task automatic cycle();
        int           g;
        logic [N-1:0] exp_rdy;
        bit           old_en;
        logic [4:0]   old_addr;
        drive();
        #1;
        g = exp_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        obs_ready = req_ready;
        obs_rs1   = rs1_busy;
        check("req_ready", req_ready, exp_rdy);
        check("rs1_busy", rs1_busy, exp_busy(rs1_addr));
        check("rs2_busy", rs2_busy, exp_busy(rs2_addr));
        @(posedge clk);
        old_en   = m_wr_en;
        old_addr = m_wr_addr;
        m_wr_en  = 1'b0;
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (m_rd[g] != 0) begin
                m_wr_en   = 1'b1;
                m_wr_addr = m_rd[g];
                m_wr_data = m_data[g];
            end
            m_v[g] = 1'b0;
        end
        if (old_en) m_busy[old_addr] = 1'b0;
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        #1;
        obs_wr_en   = wr_en;
        obs_wr_addr = wr_addr;
        obs_wr_data = wr_data;
        check("wr_en", wr_en, m_wr_en);
        check("wr_addr", wr_addr, m_wr_addr);
        check("wr_data", wr_data, m_wr_data);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        wb_stall    = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        model_reset();
        for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'(i));
        drive();
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", req_ready, '0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, '0);
        check("rst_wr_data", wr_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // All three valid and held: grants rotate 0,1,2 back to back
        set_req(WB_ALU, 5'd1, 32'h1111_0001);
        set_req(WB_LSU, 5'd2, 32'h2222_0002);
        set_req(WB_MDU, 5'd3, 32'h3333_0003);
        cycle(); check("ord0_ready", obs_ready, 3'b001); check("ord0_addr", obs_wr_addr, 5'd1);
        cycle(); check("ord1_ready", obs_ready, 3'b010); check("ord1_addr", obs_wr_addr, 5'd2);
        cycle(); check("ord2_ready", obs_ready, 3'b100); check("ord2_addr", obs_wr_addr, 5'd3);
        check("ord2_wr_en", obs_wr_en, 1'b1);
        cycle(); check("idle_wr_en", obs_wr_en, 1'b0); check("idle_hold_addr", obs_wr_addr, 5'd3);

        // Lone LSU request
        set_req(WB_LSU, 5'd5, 32'hDEAD_BEEF);
        cycle();
        check("lsu_ready", obs_ready, 3'b010);
        check("lsu_wr_en", obs_wr_en, 1'b1);
        check("lsu_wr_addr", obs_wr_addr, 5'd5);
        check("lsu_wr_data", obs_wr_data, 32'hDEAD_BEEF);
        for (int i = 0; i < N; i++) set_req(i, 5'(10 + i), $urandom);
        cycle(); check("ptr2_ready", obs_ready, 3'b100);

        // Stall with everyone waiting, then release to the pointer's requester
        set_req(WB_MDU, 5'd13, 32'hCAFE_0013);
        wb_stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("stall_ready", obs_ready, '0);
            check("stall_wr_en", obs_wr_en, 1'b0);
        end
        wb_stall = 1'b0;
        cycle(); check("unstall_ready", obs_ready, 3'b001);
        cycle();
        cycle();

        // Write to x0 is accepted and rotates, but never writes
        set_req(WB_ALU, 5'd0, 32'h0000_1234);
        cycle();
        check("x0_ready", obs_ready, 3'b001);
        check("x0_wr_en", obs_wr_en, 1'b0);
        set_req(WB_ALU, 5'd4, 32'h4);
        set_req(WB_LSU, 5'd6, 32'h6);
        cycle(); check("x0_ptr_ready", obs_ready, 3'b010);
        cycle();

        // Scoreboard set, bypassed clear, and set winning over clear
        rs1_addr    = 5'd7;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        cycle();
        issue_valid = 1'b0;
        cycle(); check("sb_set", obs_rs1, SB);
        set_req(WB_ALU, 5'd7, 32'h7777_7777);
        cycle(); check("sb_pending", obs_rs1, SB);
        issue_valid = 1'b1;
        cycle(); check("sb_bypass", obs_rs1, 1'b0);
        issue_valid = 1'b0;
        cycle(); check("sb_set_wins", obs_rs1, SB);

        // Reset pulsed the cycle after a transfer
        set_req(WB_ALU, 5'd9, 32'h9999_9999);
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        rs1_addr    = 5'd9;
        cycle();
        issue_valid = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 5'd1, 32'h1);
        drive();
        #1;
        check("midrst_wr_en", wr_en, 1'b0);
        check("midrst_ready", req_ready, '0);
        check("midrst_wr_addr", wr_addr, '0);
        check("midrst_busy", rs1_busy, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(); check("postrst_wr_en", obs_wr_en, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if (!m_v[i] && $urandom_range(0, 99) < 60)
                    set_req(i, 5'($urandom_range(0, 7)), $urandom);
            wb_stall    = ($urandom_range(0, 99) < 15);
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
